// File: rtl/primechk_if.sv
// Host/responder handshake bundle for the primality tester.
// The host drives go/n; the responder returns ready/error/is_prime/res.
interface primechk_if #(
    parameter int WIDTH_LOG = 4
);
    localparam int W = 1 << WIDTH_LOG;

    logic         go;
    logic [W-1:0] n;
    logic         ready;
    logic         error;
    logic         is_prime;
    logic [W-1:0] res;

    modport master (
        output go,
        output n,
        input  ready,
        input  error,
        input  is_prime,
        input  res
    );

    modport slave (
        input  go,
        input  n,
        output ready,
        output error,
        output is_prime,
        output res
    );
endinterface

// File: rtl/primechk.sv
// Primality tester: odd trial division with a bit-serial restoring divider.
// Reports is_prime and the smallest factor >1 (n itself when prime, 0 when n<2).
// Trial divisors run d = 3, 5, 7, ... while d*d <= n; d*d is tracked
// incrementally in sq so no multiplier is needed.
module primechk #(
    parameter int WIDTH_LOG = 4
) (
    input  logic       clk,
    input  logic       rst,
    primechk_if.slave  bus
);
    localparam int W = 1 << WIDTH_LOG;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        TEST  = 3'd2,
        DIV   = 3'd3,
        REM   = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;

    // Control / result registers (reset)
    logic                 ready;
    logic                 ready_next;
    logic                 error;
    logic                 error_next;
    logic                 is_prime;
    logic                 is_prime_next;
    logic [W-1:0]         res;
    logic [W-1:0]         res_next;

    // Datapath registers (not reset; always loaded before use)
    logic [W-1:0]         n_r;
    logic [W-1:0]         n_next;
    logic [W-1:0]         d;
    logic [W-1:0]         d_next;
    logic [2*W-1:0]       sq;
    logic [2*W-1:0]       sq_next;
    logic [W:0]           rem;
    logic [W:0]           rem_next;
    logic [WIDTH_LOG-1:0] cnt;
    logic [WIDTH_LOG-1:0] cnt_next;

    // Partial remainder after shifting in the current dividend bit
    logic [W:0]           rem_shift;

    assign bus.ready    = ready;
    assign bus.error    = error;
    assign bus.is_prime = is_prime;
    assign bus.res      = res;

    // Next-state, datapath and result logic; everything holds by default
    always_comb begin
        state_next    = state;
        ready_next    = ready;
        is_prime_next = is_prime;
        res_next      = res;
        n_next        = n_r;
        d_next        = d;
        sq_next       = sq;
        rem_next      = rem;
        cnt_next      = cnt;

        // A go seen while busy is a protocol error; it sticks until rst
        error_next    = error | (bus.go & ~ready);

        rem_shift     = {rem[W-1:0], n_r[cnt]};

        case (state)
            IDLE: begin
                if (bus.go && ready && !error) begin
                    n_next     = bus.n;
                    ready_next = 1'b0;
                    state_next = CHECK;
                end
            end

            CHECK: begin
                if (n_r < W'(2)) begin
                    res_next      = '0;
                    is_prime_next = 1'b0;
                    ready_next    = 1'b1;
                    state_next    = IDLE;
                end else if (n_r == W'(2)) begin
                    res_next      = W'(2);
                    is_prime_next = 1'b1;
                    ready_next    = 1'b1;
                    state_next    = IDLE;
                end else if (!n_r[0]) begin
                    res_next      = W'(2);
                    is_prime_next = 1'b0;
                    ready_next    = 1'b1;
                    state_next    = IDLE;
                end else begin
                    d_next        = W'(3);
                    sq_next       = (2*W)'(9);
                    state_next    = TEST;
                end
            end

            TEST: begin
                // Once d*d exceeds n no factor remains to be found
                if (sq > {{W{1'b0}}, n_r}) begin
                    res_next      = n_r;
                    is_prime_next = 1'b1;
                    ready_next    = 1'b1;
                    state_next    = IDLE;
                end else begin
                    rem_next      = '0;
                    cnt_next      = WIDTH_LOG'(W - 1);
                    state_next    = DIV;
                end
            end

            DIV: begin
                // One restoring-division step per cycle, MSB first
                if (rem_shift >= {1'b0, d}) begin
                    rem_next = rem_shift - {1'b0, d};
                end else begin
                    rem_next = rem_shift;
                end
                cnt_next = cnt - WIDTH_LOG'(1);
                if (cnt == '0) begin
                    state_next = REM;
                end
            end

            REM: begin
                if (rem == '0) begin
                    res_next      = d;
                    is_prime_next = 1'b0;
                    ready_next    = 1'b1;
                    state_next    = IDLE;
                end else begin
                    // (d+2)^2 = d^2 + 4d + 4, computed from the old d
                    sq_next    = sq + {{(W-2){1'b0}}, d, 2'b00} + (2*W)'(4);
                    d_next     = d + W'(2);
                    state_next = TEST;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and control/result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            error    <= 1'b0;
            is_prime <= 1'b0;
            res      <= '0;
        end else begin
            state    <= state_next;
            ready    <= ready_next;
            error    <= error_next;
            is_prime <= is_prime_next;
            res      <= res_next;
        end
    end

    // Datapath registers; a reset abandons them and they reload on the next go
    always_ff @(posedge clk) begin
        n_r <= n_next;
        d   <= d_next;
        sq  <= sq_next;
        rem <= rem_next;
        cnt <= cnt_next;
    end
endmodule

// File: tb/tb_primechk.sv
// Self-checking bench for primechk (WIDTH_LOG=4): directed corner cases,
// protocol error, mid-run reset, and random candidates against a plain
// arithmetic trial-division reference.
module tb_primechk;
    localparam int WL = 4;
    localparam int W  = 1 << WL;
    localparam int LIMIT = 5000;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    primechk_if #(.WIDTH_LOG(WL)) bus ();

    primechk #(.WIDTH_LOG(WL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: smallest factor by plain trial division; latency counts the
    // go edge, the CHECK edge, (W+2) edges per divisor tried, and one final
    // TEST edge when no divisor is found.
    task automatic ref_model(input int nv, output int r, output int p, output int lat);
        int k;
        bit found;
        k = 0;
        found = 0;
        r = nv;
        p = 1;
        if (nv < 2) begin
            r = 0; p = 0; lat = 2;
        end else if (nv == 2) begin
            r = 2; p = 1; lat = 2;
        end else if (nv % 2 == 0) begin
            r = 2; p = 0; lat = 2;
        end else begin
            for (int dv = 3; dv * dv <= nv && !found; dv += 2) begin
                k++;
                if (nv % dv == 0) begin
                    r = dv; p = 0; found = 1;
                end
            end
            lat = found ? 2 + k * (W + 2) : 3 + k * (W + 2);
        end
    endtask

    task automatic run_req(input int nv);
        int er, ep, el, lat;
        logic [W-1:0] prev_res;
        ref_model(nv, er, ep, el);
        prev_res = bus.res;
        @(negedge clk);
        bus.n  = W'(nv);
        bus.go = 1'b1;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        chk($sformatf("hold_res n=%0d", nv), 32'(bus.res), 32'(prev_res));
        lat = 1;
        while (!bus.ready && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("latency n=%0d", nv), 32'(lat), 32'(el));
        chk($sformatf("res n=%0d", nv), 32'(bus.res), 32'(er));
        chk($sformatf("is_prime n=%0d", nv), 32'(bus.is_prime), 32'(ep));
        chk($sformatf("error n=%0d", nv), 32'(bus.error), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst ready", 32'(bus.ready), 32'd1);
        chk("rst error", 32'(bus.error), 32'd0);
        chk("rst res", 32'(bus.res), 32'd0);
        chk("rst is_prime", 32'(bus.is_prime), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int directed [$] = '{97, 91, 9, 3, 0, 1, 2, 65534, 65521, 65535, 25, 15};
        int lat;
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        bus.go = 1'b0;
        bus.n  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("init ready", 32'(bus.ready), 32'd1);
        chk("init error", 32'(bus.error), 32'd0);
        chk("init res", 32'(bus.res), 32'd0);
        chk("init is_prime", 32'(bus.is_prime), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (directed[i]) run_req(directed[i]);

        // Reset wins over go on the same edge
        @(negedge clk);
        rst = 1'b1;
        bus.go = 1'b1;
        bus.n = W'(9);
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        chk("rst_vs_go ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vs_go no_start res", 32'(bus.res), 32'd0);

        // go while busy raises error; the running request still completes
        @(negedge clk);
        bus.n = W'(97);
        bus.go = 1'b1;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.n = W'(5);
        bus.go = 1'b1;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        chk("busy_go error", 32'(bus.error), 32'd1);
        chk("busy_go ready", 32'(bus.ready), 32'd0);
        lat = 0;
        while (!bus.ready && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("err_run res", 32'(bus.res), 32'd97);
        chk("err_run is_prime", 32'(bus.is_prime), 32'd1);
        @(negedge clk);
        bus.n = W'(9);
        bus.go = 1'b1;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("err_ignore ready", 32'(bus.ready), 32'd1);
        chk("err_ignore res", 32'(bus.res), 32'd97);
        chk("err_ignore error", 32'(bus.error), 32'd1);
        pulse_reset();

        // Reset during DIV of 91 abandons it
        @(negedge clk);
        bus.n = W'(91);
        bus.go = 1'b1;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        repeat (6) @(posedge clk);
        pulse_reset();
        run_req(25);

        // Random candidates, mostly small, a few across the full range
        for (int i = 0; i < 30; i++) begin
            if (i % 6 == 5) run_req(int'($urandom_range(0, 65535)));
            else            run_req(int'($urandom_range(0, 4095)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
